writeback_ctrl: RTL and testbench

- Sequences the register-file write-back phase of the multicycle datapath.
- After main control has decoded an instruction, this block classifies it, waits for the execute/memory handshake, then drives the destination-select code (flagRegDist) and the write enable into the destination mux and register bank.
- It is the producer end of the register-destination select interface.
- Handles one- and two-write instructions (pop writes rt then $sp) and has an execute watchdog.

---
 rtl/wb_pkg.sv | 60 ++++++
 rtl/writeback_ctrl_if.sv | 9 +
 rtl/wb_decode.sv | 39 +++
 rtl/writeback_ctrl.sv | 109 ++++++++++
 tb/tb_writeback_ctrl.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared write-back types and constants.
// Select codes, opcodes, class and state enums.
package wb_pkg;

  localparam logic [2:0] SEL_RT  = 3'b000;
  localparam logic [2:0] SEL_RD  = 3'b001;
  localparam logic [2:0] SEL_RA  = 3'b010;
  localparam logic [2:0] SEL_RSV = 3'b011;
  localparam logic [2:0] SEL_SP  = 3'b100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_PUSH  = 6'h3E;
  localparam logic [5:0] OP_POP   = 6'h3F;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [2:0] {
    NOWRITE, RT, RD, RA, SP, RT_SP, ILLEGAL
  } wb_class_e;

  typedef enum logic [2:0] {
    IDLE, WAIT_EXEC, WB1, WB2, DONE
  } wb_state_e;

  // Destination of the first write for a class.
  function automatic logic [2:0] first_sel(
    input wb_class_e c
  );
    logic [2:0] s;
    s = SEL_RT;
    unique case (c)
      RD:      s = SEL_RD;
      RA:      s = SEL_RA;
      SP:      s = SEL_SP;
      default: s = SEL_RT;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/writeback_ctrl_if.sv
// Register-destination select bundle.
// Producer drives select code and write enable.
interface writeback_ctrl_if;
  logic [2:0] flagRegDist;
  logic       regWrite;

  modport master (output flagRegDist, regWrite);
  modport slave  (input  flagRegDist, regWrite);
endinterface

// File: rtl/wb_decode.sv
// Opcode/funct to write-back class.
// Pure combinational, shared with hazard logic.
module wb_decode
  import wb_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output wb_class_e  cls
);

  logic rtype, fn_nw, op_nw, op_rt;

  assign rtype = (opcode == OP_RTYPE);
  assign fn_nw = funct inside {
    FN_JR, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU
  };
  assign op_nw = opcode inside {
    OP_J, OP_BEQ, OP_BNE, OP_SW, OP_SB, OP_SH
  };
  assign op_rt = opcode inside {
    OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
    OP_ORI, OP_LUI, OP_LB, OP_LH, OP_LW
  };

  // Mutually exclusive class terms.
  always_comb begin
    cls = ILLEGAL;
    unique case (1'b1)
      rtype && !fn_nw:          cls = RD;
      (rtype && fn_nw) || op_nw: cls = NOWRITE;
      opcode == OP_JAL:         cls = RA;
      op_rt:                    cls = RT;
      opcode == OP_PUSH:        cls = SP;
      opcode == OP_POP:         cls = RT_SP;
      default:                  cls = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/writeback_ctrl.sv
// Write-back sequencer for the multicycle core.
// Waits on execute, then drives select/write enable.
module writeback_ctrl
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       exec_done,
  writeback_ctrl_if.master dest,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic       timeout_err
);

  localparam logic [8:0] TO = 9'(TIMEOUT);

  wb_class_e cls;
  wb_class_e cls_q;
  wb_state_e state;
  logic [7:0] cnt;
  logic       expire;

  wb_decode u_dec (
    .opcode (opcode),
    .funct  (funct),
    .cls    (cls)
  );

  assign expire = ({1'b0, cnt} + 9'd1) >= TO;

  // Sequencer with registered outputs; pulses default low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      cls_q            <= NOWRITE;
      cnt              <= '0;
      dest.flagRegDist <= SEL_RT;
      dest.regWrite    <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      illegal          <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      dest.flagRegDist <= SEL_RT;
      dest.regWrite    <= 1'b0;
      done             <= 1'b0;
      illegal          <= 1'b0;
      timeout_err      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (cls == ILLEGAL) begin
              illegal <= 1'b1;
            end else begin
              cls_q <= cls;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= WAIT_EXEC;
            end
          end
        end
        WAIT_EXEC: begin
          if (exec_done) begin
            if (cls_q == NOWRITE) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              dest.regWrite    <= 1'b1;
              dest.flagRegDist <= first_sel(cls_q);
              state            <= WB1;
            end
          end else if (expire) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
        end
        WB1: begin
          if (cls_q == RT_SP) begin
            dest.regWrite    <= 1'b1;
            dest.flagRegDist <= SEL_SP;
            state            <= WB2;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        WB2: begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_ctrl.sv
// Bench for writeback_ctrl.
// Per-cycle trace model from instruction class rules.
module tb_writeback_ctrl;

  localparam int TO = 4;

  localparam int K_NW   = 0;
  localparam int K_RT   = 1;
  localparam int K_RD   = 2;
  localparam int K_RA   = 3;
  localparam int K_SP   = 4;
  localparam int K_RTSP = 5;
  localparam int K_ILL  = 6;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic       exec_done = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       busy, done, illegal, timeout_err;

  int checks = 0;
  int errors = 0;

  writeback_ctrl_if dest ();

  writeback_ctrl #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .opcode      (opcode),
    .funct       (funct),
    .exec_done   (exec_done),
    .dest        (dest),
    .busy        (busy),
    .done        (done),
    .illegal     (illegal),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] obs();
    return {busy, dest.regWrite, dest.flagRegDist,
            done, illegal, timeout_err};
  endfunction

  function automatic int ref_class(
    input logic [5:0] op, input logic [5:0] fn
  );
    case (op)
      6'h00: begin
        if (fn inside {6'h08, 6'h18, 6'h19, 6'h1A, 6'h1B})
          return K_NW;
        return K_RD;
      end
      6'h02, 6'h04, 6'h05,
      6'h2B, 6'h28, 6'h29: return K_NW;
      6'h03: return K_RA;
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D,
      6'h0F, 6'h20, 6'h21, 6'h23: return K_RT;
      6'h3E: return K_SP;
      6'h3F: return K_RTSP;
      default: return K_ILL;
    endcase
  endfunction

  function automatic logic [2:0] sel_of(input int c, input int n);
    if (n == 1) return 3'b100;
    case (c)
      K_RD:    return 3'b001;
      K_RA:    return 3'b010;
      K_SP:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic check(
    input string tag, input logic [7:0] got, input logic [7:0] exp
  );
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, got, exp);
    end
  endtask

  // One instruction: exec_done at WAIT cycle w (w>=TO: never).
  task automatic run_txn(
    input logic [5:0] op, input logic [5:0] fn,
    input int w, input bit noise
  );
    int c, nw, dk, n;
    logic b, rw, d, il, te;
    logic [2:0] sel;
    c = ref_class(op, fn);
    nw = (c == K_NW) ? 0 : (c == K_RTSP) ? 2 : 1;
    dk = w + 2 + nw;
    if (c == K_ILL) n = 1;
    else if (w >= TO) n = TO + 1;
    else n = dk + 1;
    @(negedge clk);
    start = 1'b1;
    opcode = op;
    funct = fn;
    exec_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      b = 0; rw = 0; sel = 3'b000; d = 0; il = 0; te = 0;
      if (c == K_ILL) begin
        il = (k == 1);
      end else if (w >= TO) begin
        b = (k <= TO);
        te = (k == TO + 1);
      end else begin
        b = (k <= dk);
        d = (k == dk);
        if (k >= w + 2 && k < w + 2 + nw) begin
          rw = 1;
          sel = sel_of(c, k - (w + 2));
        end
      end
      check($sformatf("op%02h_fn%02h_w%0d_k%0d", op, fn, w, k),
            obs(), {b, rw, sel, d, il, te});
      opcode = 6'($urandom);
      funct = 6'($urandom);
      start = noise && b &&
              (k == 2 || $urandom_range(0, 3) == 0);
      if (c != K_ILL && k <= w + 1 && k <= TO)
        exec_done = (k == w + 1);
      else
        exec_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    start = 1'b0;
    exec_done = 1'b0;
  endtask

  logic [5:0] ops [24] = '{
    6'h00, 6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
    6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h20, 6'h21, 6'h23,
    6'h28, 6'h29, 6'h2B, 6'h3E, 6'h3F, 6'h3A, 6'h01, 6'h3B
  };
  logic [5:0] fns [8] = '{
    6'h08, 6'h18, 6'h19, 6'h1A, 6'h1B, 6'h20, 6'h21, 6'h2A
  };

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("reset", obs(), 8'h00);
    reset_n = 1'b1;

    run_txn(6'h00, 6'h20, 1, 1'b0);
    run_txn(6'h03, 6'h00, 0, 1'b0);
    run_txn(6'h3F, 6'h00, 2, 1'b0);
    run_txn(6'h2B, 6'h00, 1, 1'b0);
    run_txn(6'h00, 6'h08, 0, 1'b0);
    run_txn(6'h3A, 6'h00, 0, 1'b0);
    run_txn(6'h3E, 6'h00, TO - 1, 1'b0);
    run_txn(6'h23, 6'h00, TO, 1'b1);

    // Asynchronous reset in the middle of WB1.
    @(negedge clk);
    start = 1'b1; opcode = 6'h00; funct = 6'h20;
    @(negedge clk);
    start = 1'b0; exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
    check("pre_rst_wb1", obs(), 8'b1_1_001_000);
    #2 reset_n = 1'b0;
    #1 check("async_rst", obs(), 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst", obs(), 8'h00);

    for (int i = 0; i < 150; i++) begin
      run_txn(ops[$urandom_range(0, 23)],
              fns[$urandom_range(0, 7)],
              $urandom_range(0, TO), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
